ks_pipe_subtractor: RTL



---
 rtl/ks_pipe_subtractor.sv | 91 +++++++++
 1 files changed

// File: rtl/ks_pipe_subtractor.sv
// ks_pipe_subtractor: pipelined Kogge-Stone a - b - bin with valid/ready streaming
// Ports: clk/rst_n (async active-low); in_valid/in_ready + a, b, bin operands;
// out_valid/out_ready + diff, borrow (a < b + bin), ovf (signed), zero (diff == 0).
// Six register stages for WIDTH=16: pre-process, LEVELS prefix levels, output.
module ks_pipe_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);
  localparam int LEVELS = $clog2(WIDTH);
  logic             en;
  logic [LEVELS:0]  v;
  logic [LEVELS:0]  c0_s;
  logic [LEVELS:0]  am_s;
  logic [LEVELS:0]  bm_s;
  logic [WIDTH-1:0] p_s  [0:LEVELS];
  logic [WIDTH-1:0] pg_p [0:LEVELS];
  logic [WIDTH-1:0] pg_g [0:LEVELS];
  logic [WIDTH-1:0] nx_p [1:LEVELS];
  logic [WIDTH-1:0] nx_g [1:LEVELS];
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] dn;
  logic             cout;
  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign bb = ~b;
  // Bits below the level distance see shifted-in zeros for G and ones for P,
  // which makes them pass through unchanged.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    assign nx_g[k] = pg_g[k-1] | (pg_p[k-1] & {pg_g[k-1][WIDTH-1-D:0], {D{1'b0}}});
    assign nx_p[k] = pg_p[k-1] & {pg_p[k-1][WIDTH-1-D:0], {D{1'b1}}};
  end
  // Carry-in c0 = ~bin is folded in here rather than into the prefix tree.
  assign carry = {pg_g[LEVELS][WIDTH-2:0] | (pg_p[LEVELS][WIDTH-2:0] & {(WIDTH-1){c0_s[LEVELS]}}),
                  c0_s[LEVELS]};
  assign dn = p_s[LEVELS] ^ carry;
  assign cout = pg_g[LEVELS][WIDTH-1] | (pg_p[LEVELS][WIDTH-1] & c0_s[LEVELS]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      c0_s <= '0;
      am_s <= '0;
      bm_s <= '0;
      for (int i = 0; i <= LEVELS; i++) begin
        p_s[i] <= '0;
        pg_p[i] <= '0;
        pg_g[i] <= '0;
      end
      out_valid <= 1'b0;
      diff <= '0;
      borrow <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (en) begin
      v <= {v[LEVELS-1:0], in_valid};
      p_s[0] <= a ^ bb;
      pg_p[0] <= a ^ bb;
      pg_g[0] <= a & bb;
      c0_s[0] <= ~bin;
      am_s[0] <= a[WIDTH-1];
      bm_s[0] <= bb[WIDTH-1];
      for (int i = 1; i <= LEVELS; i++) begin
        p_s[i] <= p_s[i-1];
        pg_p[i] <= nx_p[i];
        pg_g[i] <= nx_g[i];
        c0_s[i] <= c0_s[i-1];
        am_s[i] <= am_s[i-1];
        bm_s[i] <= bm_s[i-1];
      end
      out_valid <= v[LEVELS];
      diff <= dn;
      borrow <= ~cout;
      ovf <= (am_s[LEVELS] == bm_s[LEVELS]) & (dn[WIDTH-1] != am_s[LEVELS]);
      zero <= ~|dn;
    end
  end
endmodule
